// File: rtl/ysyx_23060180_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060180_lsu
// Purpose  : Single-outstanding load/store unit. It handles byte, halfword and
//            word accesses to a variable-latency data memory port. Define
//            LSU_TIMEOUT_EN to add a watchdog on the REQ/WAIT phase.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060180_lsu #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    if (TIMEOUT_CYCLES < 1 || TO_CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_params
        $error("TO_CNT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [1:0]  r_state;
    logic        r_we;
    logic [2:0]  r_func3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic [31:0] r_resp_rdata;
    logic [4:0]  r_resp_rd;
    logic        r_resp_err;

    logic        w_func_ok;
    logic        w_align_ok;
    logic        w_legal;
    logic [1:0]  w_off;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_mask;
    logic [31:0] w_shifted;
    logic [31:0] w_ld_data;
    logic        w_in_req;
    logic        w_in_st;
    logic        w_timeout;

    // Legality is decided on the raw request so errors skip the memory port.
    always_comb begin
        w_func_ok  = 1'b0;
        w_align_ok = 1'b1;
        if (req_we) begin
            w_func_ok = (req_func3 == 3'd0) || (req_func3 == 3'd1) || (req_func3 == 3'd2);
        end else begin
            case (req_func3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_func_ok = 1'b1;
                default:                      w_func_ok = 1'b0;
            endcase
        end
        case (req_func3[1:0])
            2'b01:   w_align_ok = ~req_addr[0];
            2'b10:   w_align_ok = (req_addr[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
        w_legal = w_func_ok & w_align_ok;
    end

    assign w_off = r_addr[1:0];

    always_comb begin
        w_st_data = r_wdata;
        w_st_mask = 4'hF;
        case (r_func3[1:0])
            2'b00: begin
                w_st_data = {4{r_wdata[7:0]}};
                w_st_mask = 4'b0001 << w_off;
            end
            2'b01: begin
                w_st_data = {2{r_wdata[15:0]}};
                w_st_mask = 4'b0011 << w_off;
            end
            default: begin
                w_st_data = r_wdata;
                w_st_mask = 4'hF;
            end
        endcase
    end

    assign w_shifted = dmem_rdata >> {w_off, 3'b000};

    always_comb begin
        case (r_func3)
            3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ld_data = {24'h0, w_shifted[7:0]};
            3'b101:  w_ld_data = {16'h0, w_shifted[15:0]};
            default: w_ld_data = w_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] c_TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TO_CNT_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (req_valid && req_ready) begin
            r_to_cnt <= '0;
        end else if (r_state == c_ST_REQ || r_state == c_ST_WAIT) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Fires on the last allowed REQ/WAIT cycle; completion is checked first.
    assign w_timeout = (r_state == c_ST_REQ || r_state == c_ST_WAIT) && (r_to_cnt == c_TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_we         <= 1'b0;
            r_func3      <= 3'd0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_rd         <= 5'd0;
            r_resp_rdata <= 32'h0;
            r_resp_rd    <= 5'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_func3 <= req_func3;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rd    <= req_rd;
                        if (w_legal) begin
                            r_state <= c_ST_REQ;
                        end else begin
                            r_state      <= c_ST_RESP;
                            r_resp_rdata <= 32'h0;
                            r_resp_rd    <= 5'd0;
                            r_resp_err   <= 1'b1;
                        end
                    end
                end
                c_ST_REQ: begin
                    if (dmem_gnt) begin
                        if (r_we) begin
                            r_state      <= c_ST_RESP;
                            r_resp_rdata <= 32'h0;
                            r_resp_rd    <= 5'd0;
                            r_resp_err   <= 1'b0;
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end else if (w_timeout) begin
                        r_state      <= c_ST_RESP;
                        r_resp_rdata <= 32'h0;
                        r_resp_rd    <= 5'd0;
                        r_resp_err   <= 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (dmem_rvalid) begin
                        r_state      <= c_ST_RESP;
                        r_resp_rdata <= w_ld_data;
                        r_resp_rd    <= r_rd;
                        r_resp_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state      <= c_ST_RESP;
                        r_resp_rdata <= 32'h0;
                        r_resp_rd    <= 5'd0;
                        r_resp_err   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign w_in_req   = (r_state == c_ST_REQ);
    assign w_in_st    = w_in_req & r_we;
    assign req_ready  = (r_state == c_ST_IDLE);
    assign dmem_req   = w_in_req;
    assign dmem_we    = w_in_st;
    assign dmem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign dmem_wdata = w_in_st ? w_st_data : 32'h0;
    assign dmem_wmask = w_in_st ? w_st_mask : 4'h0;
    assign resp_valid = (r_state == c_ST_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_rd    = r_resp_rd;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060180_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060180_lsu
// Purpose  : Self-checking bench for the load/store unit; expected responses
//            are queued at request time and popped when resp_valid appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060180_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic [3:0]  g;
        logic [3:0]  v;
    } ld_vec_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_mask;
        logic [3:0]  g;
    } st_vec_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
    } er_vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    ysyx_23060180_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_func3   (req_func3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wmask  (dmem_wmask),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_rd     (resp_rd),
        .resp_err    (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
        else n_pass++;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0) $display("FAIL reset_resp_flags: valid=%b err=%b want 0 0", resp_valid, resp_err);
        else n_pass++;
        n_checks++;
        if (resp_rdata !== 32'h0 || resp_rd !== 5'd0) $display("FAIL reset_resp_data: rdata=%h rd=%0d want 0 0", resp_rdata, resp_rd);
        else n_pass++;
        n_checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0) $display("FAIL reset_dmem_ctl: req=%b we=%b want 0 0", dmem_req, dmem_we);
        else n_pass++;
        n_checks++;
        if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_wmask !== 4'h0)
            $display("FAIL reset_dmem_data: addr=%h wdata=%h wmask=%h want 0 0 0", dmem_addr, dmem_wdata, dmem_wmask);
        else n_pass++;
    endtask

    task automatic test_loads();
        ld_vec_t tbl [8];
        exp_t    e;
        int      t0;
        int      lat;
        int      g;
        int      v;
        tbl[0] = '{3'd2, 32'h8000_0100, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 4'd0, 4'd0};
        tbl[1] = '{3'd0, 32'h8000_0103, 32'h80FF_1234, 5'd1,  32'hFFFF_FF80, 4'd0, 4'd0};
        tbl[2] = '{3'd4, 32'h8000_0103, 32'h80FF_1234, 5'd2,  32'h0000_0080, 4'd1, 4'd2};
        tbl[3] = '{3'd1, 32'h8000_0002, 32'h80FF_1234, 5'd10, 32'hFFFF_80FF, 4'd2, 4'd0};
        tbl[4] = '{3'd5, 32'h8000_0002, 32'h80FF_1234, 5'd11, 32'h0000_80FF, 4'd0, 4'd1};
        tbl[5] = '{3'd0, 32'h8000_0001, 32'h80FF_1234, 5'd31, 32'h0000_0012, 4'd0, 4'd0};
        tbl[6] = '{3'd1, 32'h8000_0000, 32'h0000_F00D, 5'd17, 32'hFFFF_F00D, 4'd1, 4'd1};
        tbl[7] = '{3'd4, 32'h8000_0006, 32'h80FF_1234, 5'd8,  32'h0000_00FF, 4'd0, 4'd0};
        for (int i = 0; i < 8; i++) begin
            g = int'(tbl[i].g);
            v = int'(tbl[i].v);
            req_valid = 1'b1; req_we = 1'b0; req_func3 = tbl[i].f3;
            req_addr = tbl[i].addr; req_wdata = $urandom; req_rd = tbl[i].rd;
            t0 = cyc;
            e.rdata = tbl[i].exp; e.rd = tbl[i].rd; e.err = 1'b0;
            exp_q.push_back(e);
            @(negedge clk);
            req_valid = 1'b0; req_addr = $urandom; req_func3 = 3'd3;
            for (int k = 0; k <= g; k++) begin
                n_checks++;
                if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {tbl[i].addr[31:2], 2'b00} || dmem_wmask !== 4'h0)
                    $display("FAIL load_req[%0d] cyc %0d: req=%b we=%b addr=%h wmask=%h want 1 0 %h 0",
                             i, k, dmem_req, dmem_we, dmem_addr, dmem_wmask, {tbl[i].addr[31:2], 2'b00});
                else n_pass++;
                if (k == g) dmem_gnt = 1'b1;
                @(negedge clk);
            end
            dmem_gnt = 1'b0;
            for (int k = 0; k <= v; k++) begin
                n_checks++;
                if (dmem_req !== 1'b0 || resp_valid !== 1'b0)
                    $display("FAIL load_wait[%0d] cyc %0d: dmem_req=%b resp_valid=%b want 0 0", i, k, dmem_req, resp_valid);
                else n_pass++;
                if (k == v) begin
                    dmem_rvalid = 1'b1; dmem_rdata = tbl[i].mem;
                end else begin
                    dmem_rdata = $urandom;
                end
                @(negedge clk);
            end
            dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            for (int k = 0; k < 4 && resp_valid !== 1'b1; k++) @(negedge clk);
            lat = cyc - t0;
            e = exp_q.pop_front();
            n_checks++;
            if (resp_valid !== 1'b1 || lat != 3 + g + v)
                $display("FAIL load_latency[%0d]: valid=%b latency=%0d want 1 %0d", i, resp_valid, lat, 3 + g + v);
            else n_pass++;
            n_checks++;
            if (resp_rdata !== e.rdata) $display("FAIL load_rdata[%0d]: got %h want %h", i, resp_rdata, e.rdata);
            else n_pass++;
            n_checks++;
            if (resp_rd !== e.rd || resp_err !== e.err || req_ready !== 1'b0)
                $display("FAIL load_rd_err[%0d]: rd=%0d err=%b ready=%b want %0d %b 0", i, resp_rd, resp_err, req_ready, e.rd, e.err);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== e.rdata || resp_rd !== e.rd)
                $display("FAIL load_hold[%0d]: valid=%b ready=%b rdata=%h rd=%0d want 0 1 %h %0d",
                         i, resp_valid, req_ready, resp_rdata, resp_rd, e.rdata, e.rd);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        er_vec_t tbl [8];
        exp_t    e;
        int      t0;
        int      lat;
        tbl[0] = '{1'b0, 3'd2, 32'h8000_0001};
        tbl[1] = '{1'b1, 3'd3, 32'h8000_0000};
        tbl[2] = '{1'b0, 3'd1, 32'h8000_0003};
        tbl[3] = '{1'b0, 3'd3, 32'h8000_0000};
        tbl[4] = '{1'b0, 3'd6, 32'h8000_0000};
        tbl[5] = '{1'b1, 3'd4, 32'h8000_0000};
        tbl[6] = '{1'b1, 3'd1, 32'h8000_0005};
        tbl[7] = '{1'b1, 3'd2, 32'h8000_0002};
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = tbl[i].we; req_func3 = tbl[i].f3;
            req_addr = tbl[i].addr; req_wdata = $urandom; req_rd = 5'd9;
            t0 = cyc;
            e.rdata = 32'h0; e.rd = 5'd0; e.err = 1'b1;
            exp_q.push_back(e);
            @(negedge clk);
            req_valid = 1'b0;
            for (int k = 0; k < 3 && resp_valid !== 1'b1; k++) @(negedge clk);
            lat = cyc - t0;
            e = exp_q.pop_front();
            n_checks++;
            if (resp_valid !== 1'b1 || lat != 1 || dmem_req !== 1'b0)
                $display("FAIL err_latency[%0d]: valid=%b latency=%0d dmem_req=%b want 1 1 0", i, resp_valid, lat, dmem_req);
            else n_pass++;
            n_checks++;
            if (resp_err !== e.err || resp_rdata !== e.rdata || resp_rd !== e.rd)
                $display("FAIL err_resp[%0d]: err=%b rdata=%h rd=%0d want %b %h %0d", i, resp_err, resp_rdata, resp_rd, e.err, e.rdata, e.rd);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0 || resp_err !== 1'b1 || dmem_req !== 1'b0)
                $display("FAIL err_hold[%0d]: valid=%b err=%b dmem_req=%b want 0 1 0", i, resp_valid, resp_err, dmem_req);
            else n_pass++;
        end
    endtask

    task automatic test_stores();
        st_vec_t tbl [6];
        exp_t    e;
        int      t0;
        int      lat;
        int      g;
        tbl[0] = '{3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'hABCD_ABCD, 4'b1100, 4'd0};
        tbl[1] = '{3'd0, 32'h8000_0001, 32'h1234_56AB, 32'hABAB_ABAB, 4'b0010, 4'd1};
        tbl[2] = '{3'd0, 32'h8000_0003, 32'hFFFF_FF5A, 32'h5A5A_5A5A, 4'b1000, 4'd0};
        tbl[3] = '{3'd2, 32'h8000_0008, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 4'd3};
        tbl[4] = '{3'd1, 32'h8000_0010, 32'h8765_4321, 32'h4321_4321, 4'b0011, 4'd0};
        tbl[5] = '{3'd0, 32'h8000_0000, 32'h0000_0077, 32'h7777_7777, 4'b0001, 4'd2};
        for (int i = 0; i < 6; i++) begin
            g = int'(tbl[i].g);
            req_valid = 1'b1; req_we = 1'b1; req_func3 = tbl[i].f3;
            req_addr = tbl[i].addr; req_wdata = tbl[i].wdata; req_rd = 5'd7;
            t0 = cyc;
            e.rdata = 32'h0; e.rd = 5'd0; e.err = 1'b0;
            exp_q.push_back(e);
            @(negedge clk);
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = 1'b0;
            for (int k = 0; k <= g; k++) begin
                n_checks++;
                if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== {tbl[i].addr[31:2], 2'b00} ||
                    dmem_wdata !== tbl[i].exp_wdata || dmem_wmask !== tbl[i].exp_mask)
                    $display("FAIL store_req[%0d] cyc %0d: req=%b we=%b addr=%h wdata=%h wmask=%b want 1 1 %h %h %b",
                             i, k, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
                             {tbl[i].addr[31:2], 2'b00}, tbl[i].exp_wdata, tbl[i].exp_mask);
                else n_pass++;
                if (k == g) dmem_gnt = 1'b1;
                @(negedge clk);
            end
            dmem_gnt = 1'b0;
            for (int k = 0; k < 3 && resp_valid !== 1'b1; k++) @(negedge clk);
            lat = cyc - t0;
            e = exp_q.pop_front();
            n_checks++;
            if (resp_valid !== 1'b1 || lat != 2 + g || dmem_req !== 1'b0)
                $display("FAIL store_latency[%0d]: valid=%b latency=%0d dmem_req=%b want 1 %0d 0", i, resp_valid, lat, dmem_req, 2 + g);
            else n_pass++;
            n_checks++;
            if (resp_rd !== e.rd || resp_rdata !== e.rdata || resp_err !== e.err)
                $display("FAIL store_resp[%0d]: rd=%0d rdata=%h err=%b want %0d %h %b", i, resp_rd, resp_rdata, resp_err, e.rd, e.rdata, e.err);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1)
                $display("FAIL store_pulse[%0d]: valid=%b ready=%b want 0 1", i, resp_valid, req_ready);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd2;
        req_addr = 32'h8000_0200; req_wdata = 32'h0; req_rd = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dmem_req !== 1'b0)
            $display("FAIL rstmid_state: valid=%b ready=%b dmem_req=%b want 0 1 0", resp_valid, req_ready, dmem_req);
        else n_pass++;
        n_checks++;
        if (resp_rdata !== 32'h0 || resp_rd !== 5'd0 || resp_err !== 1'b0)
            $display("FAIL rstmid_resp: rdata=%h rd=%0d err=%b want 0 0 0", resp_rdata, resp_rd, resp_err);
        else n_pass++;
        dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0)
                $display("FAIL rstmid_late[%0d]: valid=%b ready=%b rdata=%h want 0 1 0", k, resp_valid, req_ready, resp_rdata);
            else n_pass++;
        end
        dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
    endtask

    task automatic test_timeout();
        exp_t e;
        int   t0;
        int   lat;
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd2;
        req_addr = 32'h8000_0300; req_wdata = 32'h0; req_rd = 5'd6;
        t0 = cyc;
`ifdef LSU_TIMEOUT_EN
        e.rdata = 32'h0; e.rd = 5'd0; e.err = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 40 && resp_valid !== 1'b1; k++) @(negedge clk);
        lat = cyc - t0;
        e = exp_q.pop_front();
        n_checks++;
        if (resp_valid !== 1'b1 || lat != 17 || dmem_req !== 1'b0)
            $display("FAIL timeout_latency: valid=%b latency=%0d dmem_req=%b want 1 17 0", resp_valid, lat, dmem_req);
        else n_pass++;
        n_checks++;
        if (resp_err !== e.err || resp_rdata !== e.rdata || resp_rd !== e.rd)
            $display("FAIL timeout_resp: err=%b rdata=%h rd=%0d want %b %h %0d", resp_err, resp_rdata, resp_rd, e.err, e.rdata, e.rd);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL timeout_ready: ready=%b valid=%b want 1 0", req_ready, resp_valid);
        else n_pass++;
`else
        e.rdata = 32'h0000_0042; e.rd = 5'd6; e.err = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (dmem_req !== 1'b1 || resp_valid !== 1'b0)
                $display("FAIL stall_hold[%0d]: dmem_req=%b valid=%b want 1 0", k, dmem_req, resp_valid);
            else n_pass++;
            @(negedge clk);
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0042;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        for (int k = 0; k < 3 && resp_valid !== 1'b1; k++) @(negedge clk);
        lat = cyc - t0;
        e = exp_q.pop_front();
        n_checks++;
        if (resp_valid !== 1'b1 || lat != 23)
            $display("FAIL stall_latency: valid=%b latency=%0d want 1 23", resp_valid, lat);
        else n_pass++;
        n_checks++;
        if (resp_err !== e.err || resp_rdata !== e.rdata || resp_rd !== e.rd)
            $display("FAIL stall_resp: err=%b rdata=%h rd=%0d want %b %h %0d", resp_err, resp_rdata, resp_rd, e.err, e.rdata, e.rd);
        else n_pass++;
        @(negedge clk);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_loads();
        test_errors();
        test_stores();
        test_loads();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
